// File: rtl/red_centroid_pkg.sv
// Shared constants and FSM encoding for the red-pixel centroid tracker.
// Optional bounding-box outputs are enabled by RED_CENTROID_BBOX_EN.
package red_centroid_pkg;

  localparam int IMG_W_DEF   = 320;
  localparam int IMG_H_DEF   = 240;
  localparam int MIN_PIX_DEF = 16;
  localparam int SUM_W_DEF   = 25;
  localparam int CNT_W_DEF   = 17;
  localparam int X_W         = 9;
  localparam int Y_W         = 8;

  typedef enum logic [1:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    PUBLISH
  } state_e;

endpackage

// File: rtl/red_centroid_serial_divider.sv
// Restoring divider, one quotient bit per cycle; the start cycle already
// resolves the MSB, so a full quotient takes exactly DVD_W cycles.
module serial_divider #(
  parameter int DVD_W = 25,
  parameter int DVS_W = 17,
  parameter int QUO_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  localparam int CW = $clog2(DVD_W);
  localparam logic [CW-1:0] LAST  = CW'(1);
  localparam logic [CW-1:0] STEPS = CW'(DVD_W - 1);

  logic [DVD_W-1:0] quo_q, quo_d, src_quo;
  logic [DVS_W-1:0] rem_q, rem_d, dvs_q;
  logic [DVS_W-1:0] src_rem, src_dvs;
  logic [DVS_W:0]   shifted, trial;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, ge;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    shifted = {src_rem, src_quo[DVD_W-1]};
    trial   = shifted - {1'b0, src_dvs};
    ge      = ~trial[DVS_W];
    rem_d   = ge ? trial[DVS_W-1:0] : shifted[DVS_W-1:0];
    quo_d   = {src_quo[DVD_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= divisor;
      cnt_q  <= STEPS;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);
  assign quotient = quo_q[QUO_W-1:0];

endmodule

// File: rtl/red_centroid.sv
// Per-frame centroid of red pixels with a shared serial divider.
// Define RED_CENTROID_BBOX_EN to add bounding-box outputs.
module red_centroid
  import red_centroid_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int MIN_PIXELS = MIN_PIX_DEF,
  parameter int SUM_W      = SUM_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_valid,
  input  logic             pix_red,
  input  logic             pix_sop,
  input  logic             pix_eop,
  output logic [X_W-1:0]   centroid_x,
  output logic [Y_W-1:0]   centroid_y,
  output logic [CNT_W-1:0] red_count,
  output logic             target_found,
  output logic             centroid_valid,
`ifdef RED_CENTROID_BBOX_EN
  output logic [X_W-1:0]   bbox_xmin,
  output logic [X_W-1:0]   bbox_xmax,
  output logic [Y_W-1:0]   bbox_ymin,
  output logic [Y_W-1:0]   bbox_ymax,
`endif
  output logic             busy,
  output logic             overrun
);

  localparam logic [X_W-1:0]   COL_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   ROW_LAST = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_PIXELS);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // async assert, release synchronised to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e           state_q;
  logic [X_W-1:0]   col_q, col_d, cur_col;
  logic [Y_W-1:0]   row_q, row_d, cur_row;
  logic [SUM_W-1:0] sx_q, sx_d, sy_q, sy_d, tot_x, tot_y;
  logic [CNT_W-1:0] cnt_q, cnt_d, tot_cnt;
  logic [SUM_W-1:0] snap_x_q, snap_y_q;
  logic [CNT_W-1:0] snap_cnt_q;
  logic             red_beat, eop_beat, eop_acc, snap_zero;

  assign red_beat  = pix_valid & pix_red;
  assign eop_beat  = pix_valid & pix_eop;
  assign eop_acc   = eop_beat & (state_q == IDLE);
  assign snap_zero = (snap_cnt_q == '0);

  always_comb begin
    cur_col = pix_sop ? '0 : col_q;
    cur_row = pix_sop ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (pix_valid) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? cur_row : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    tot_x   = (pix_sop ? '0 : sx_q)
            + (red_beat ? SUM_W'(cur_col) : '0);
    tot_y   = (pix_sop ? '0 : sy_q)
            + (red_beat ? SUM_W'(cur_row) : '0);
    tot_cnt = (pix_sop ? '0 : cnt_q) + CNT_W'(red_beat);
    sx_d    = sx_q;
    sy_d    = sy_q;
    cnt_d   = cnt_q;
    if (pix_valid) begin
      sx_d  = pix_eop ? '0 : tot_x;
      sy_d  = pix_eop ? '0 : tot_y;
      cnt_d = pix_eop ? '0 : tot_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      cnt_q      <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_cnt_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sx_q  <= sx_d;
      sy_q  <= sy_d;
      cnt_q <= cnt_d;
      if (eop_acc) begin
        snap_x_q   <= tot_x;
        snap_y_q   <= tot_y;
        snap_cnt_q <= tot_cnt;
      end
    end
  end

`ifdef RED_CENTROID_BBOX_EN
  logic [X_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d, nxmin, nxmax;
  logic [Y_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d, nymin, nymax;
  logic [X_W-1:0] sxmin_q, sxmax_q, bxmin_q, bxmax_q;
  logic [Y_W-1:0] symin_q, symax_q, bymin_q, bymax_q;

  always_comb begin
    nxmin = pix_sop ? '1 : xmin_q;
    nxmax = pix_sop ? '0 : xmax_q;
    nymin = pix_sop ? '1 : ymin_q;
    nymax = pix_sop ? '0 : ymax_q;
    if (red_beat) begin
      if (cur_col < nxmin) nxmin = cur_col;
      if (cur_col > nxmax) nxmax = cur_col;
      if (cur_row < nymin) nymin = cur_row;
      if (cur_row > nymax) nymax = cur_row;
    end
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (pix_valid) begin
      xmin_d = pix_eop ? '1 : nxmin;
      xmax_d = pix_eop ? '0 : nxmax;
      ymin_d = pix_eop ? '1 : nymin;
      ymax_d = pix_eop ? '0 : nymax;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      sxmin_q <= '0;
      sxmax_q <= '0;
      symin_q <= '0;
      symax_q <= '0;
      bxmin_q <= '0;
      bxmax_q <= '0;
      bymin_q <= '0;
      bymax_q <= '0;
    end else begin
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      if (eop_acc) begin
        sxmin_q <= nxmin;
        sxmax_q <= nxmax;
        symin_q <= nymin;
        symax_q <= nymax;
      end
      if (state_q == PUBLISH) begin
        bxmin_q <= snap_zero ? '0 : sxmin_q;
        bxmax_q <= snap_zero ? '0 : sxmax_q;
        bymin_q <= snap_zero ? '0 : symin_q;
        bymax_q <= snap_zero ? '0 : symax_q;
      end
    end
  end

  assign bbox_xmin = bxmin_q;
  assign bbox_xmax = bxmax_q;
  assign bbox_ymin = bymin_q;
  assign bbox_ymax = bymax_q;
`endif

  logic             div_start, div_busy, div_done;
  logic [SUM_W-1:0] div_dvd;
  logic [X_W-1:0]   div_quo;

  assign div_start = (state_q == DIV_X || state_q == DIV_Y) & ~div_busy;
  assign div_dvd   = (state_q == DIV_X) ? snap_x_q : snap_y_q;

  serial_divider #(
    .DVD_W(SUM_W),
    .DVS_W(CNT_W),
    .QUO_W(X_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (snap_cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  logic [X_W-1:0]   qx_q, cx_q;
  logic [Y_W-1:0]   cy_q;
  logic [CNT_W-1:0] rc_q;
  logic             tf_q, cv_q, ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      qx_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      rc_q    <= '0;
      tf_q    <= 1'b0;
      cv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cv_q <= 1'b0;
      if (eop_beat && state_q != IDLE) ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: if (eop_acc) state_q <= DIV_X;
        DIV_X: if (div_done) state_q <= DIV_Y;
        DIV_Y: begin
          // x quotient is still on the divider output as y starts
          if (div_start) qx_q <= div_quo;
          if (div_done) state_q <= PUBLISH;
        end
        PUBLISH: begin
          cx_q    <= snap_zero ? '0 : qx_q;
          cy_q    <= snap_zero ? '0 : div_quo[Y_W-1:0];
          rc_q    <= snap_cnt_q;
          tf_q    <= (snap_cnt_q >= CNT_MIN);
          cv_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign centroid_x     = cx_q;
  assign centroid_y     = cy_q;
  assign red_count      = rc_q;
  assign target_found   = tf_q;
  assign centroid_valid = cv_q;
  assign busy           = (state_q != IDLE);
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_red_centroid.sv
// Directed and randomised frames for red_centroid, checked against
// centroid arithmetic derived from each beat's raster position.
module tb_red_centroid;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int MINP  = 16;
  localparam int LAT   = 51;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_red = 1'b0;
  logic       pix_sop = 1'b0;
  logic       pix_eop = 1'b0;
  logic [8:0] centroid_x;
  logic [7:0] centroid_y;
  logic [16:0] red_count;
  logic       target_found, centroid_valid, busy, overrun;
`ifdef RED_CENTROID_BBOX_EN
  logic [8:0] bbox_xmin, bbox_xmax;
  logic [7:0] bbox_ymin, bbox_ymax;
`endif

  red_centroid dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pix_valid      (pix_valid),
    .pix_red        (pix_red),
    .pix_sop        (pix_sop),
    .pix_eop        (pix_eop),
    .centroid_x     (centroid_x),
    .centroid_y     (centroid_y),
    .red_count      (red_count),
    .target_found   (target_found),
    .centroid_valid (centroid_valid),
`ifdef RED_CENTROID_BBOX_EN
    .bbox_xmin      (bbox_xmin),
    .bbox_xmax      (bbox_xmax),
    .bbox_ymin      (bbox_ymin),
    .bbox_ymax      (bbox_ymax),
`endif
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int     ncmp = 0;
  int     nfail = 0;
  int     e_cnt;
  longint e_sx, e_sy;
  int     e_xmin, e_xmax, e_ymin, e_ymax;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input bit v, input bit r, input bit s, input bit e);
    pix_valid = v;
    pix_red   = r;
    pix_sop   = s;
    pix_eop   = e;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_red   = 1'b0;
    pix_sop   = 1'b0;
    pix_eop   = 1'b0;
  endtask

  // kind 0: rectangle x0..x1/y0..y1 red, 1: random, 2: all red
  task automatic frame(input int n, input int kind, input int x0,
                       input int x1, input int y0, input int y1,
                       input bit with_eop, input bit gaps);
    e_cnt = 0;
    e_sx = 0;
    e_sy = 0;
    e_xmin = IMG_W;
    e_xmax = -1;
    e_ymin = IMG_H;
    e_ymax = -1;
    for (int i = 0; i < n; i++) begin
      int x, y;
      bit r;
      x = i % IMG_W;
      y = i / IMG_W;
      if (y > IMG_H - 1) y = IMG_H - 1;
      case (kind)
        0: r = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
        1: r = bit'($urandom_range(0, 1));
        default: r = 1'b1;
      endcase
      if (gaps && $urandom_range(0, 3) == 0)
        beat(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
      if (r) begin
        e_cnt++;
        e_sx += x;
        e_sy += y;
        if (x < e_xmin) e_xmin = x;
        if (x > e_xmax) e_xmax = x;
        if (y < e_ymin) e_ymin = y;
        if (y > e_ymax) e_ymax = y;
      end
      beat(1'b1, r, i == 0, with_eop && (i == n - 1));
    end
  endtask

  // k0 = cycles already elapsed since the eop edge
  task automatic expect_publish(input string tag, input int k0);
    int k;
    k = k0;
    check({tag, ".busy"}, busy, 1);
    while (!centroid_valid && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, ".latency"}, k, LAT);
    check({tag, ".cx"}, centroid_x, e_cnt ? e_sx / e_cnt : 0);
    check({tag, ".cy"}, centroid_y, e_cnt ? e_sy / e_cnt : 0);
    check({tag, ".count"}, red_count, e_cnt);
    check({tag, ".found"}, target_found, e_cnt >= MINP);
`ifdef RED_CENTROID_BBOX_EN
    check({tag, ".xmin"}, bbox_xmin, e_cnt ? e_xmin : 0);
    check({tag, ".xmax"}, bbox_xmax, e_cnt ? e_xmax : 0);
    check({tag, ".ymin"}, bbox_ymin, e_cnt ? e_ymin : 0);
    check({tag, ".ymax"}, bbox_ymax, e_cnt ? e_ymax : 0);
`endif
    idle(1);
    check({tag, ".strobe1"}, centroid_valid, 0);
    check({tag, ".idle"}, busy, 0);
    check({tag, ".hold"}, red_count, e_cnt);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (centroid_valid) seen++;
    end
    check(tag, seen, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".cx"}, centroid_x, 0);
    check({tag, ".cy"}, centroid_y, 0);
    check({tag, ".count"}, red_count, 0);
    check({tag, ".found"}, target_found, 0);
    check({tag, ".valid"}, centroid_valid, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".ovr"}, overrun, 0);
`ifdef RED_CENTROID_BBOX_EN
    check({tag, ".bbox"}, {bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 0);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    idle(3);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    idle(4);

    frame(1700, 0, 10, 10, 5, 5, 1'b1, 1'b0);
    expect_publish("single", 0);

    frame(59 * IMG_W + 110, 0, 100, 109, 50, 59, 1'b1, 1'b0);
    expect_publish("block", 0);

    frame(300, 0, 1, 0, 0, 0, 1'b1, 1'b1);
    expect_publish("black", 0);

    frame(700, 1, 0, 0, 0, 0, 1'b1, 1'b1);
    idle(19);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    check("ovr.flag", overrun, 1);
    expect_publish("ovr", 20);
    expect_quiet("ovr.no2nd", 120);
    check("ovr.sticky", overrun, 1);

    frame(500, 2, 0, 0, 0, 0, 1'b0, 1'b0);
    frame(3 * IMG_W + 216, 0, 200, 215, 3, 3, 1'b1, 1'b0);
    expect_publish("midsop", 0);

    frame(400, 1, 0, 0, 0, 0, 1'b1, 1'b1);
    idle(35);
    check("rst.indivy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("rst.mid");
    idle(2);
    reset_n = 1'b1;
    expect_quiet("rst.noval", 80);
    frame(900, 1, 0, 0, 0, 0, 1'b1, 1'b1);
    expect_publish("after_rst", 0);

    frame(1, 2, 0, 0, 0, 0, 1'b1, 1'b0);
    expect_publish("onepix", 0);

    repeat (5) begin
      frame(int'($urandom_range(1, 900)), 1, 0, 0, 0, 0, 1'b1, 1'b1);
      expect_publish("rand", 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/red_centroid.md
Name: red_centroid

Overview:
- Sits directly downstream of the colour-detection stage, on the same pixel stream that feeds the VGA scaler.
- Accumulates the x/y coordinates of every red-classified pixel over one 320x240 frame.
- At end of frame it divides the sums by the red-pixel count with a sequential divider.
- Publishes centroid, count and a target-found flag once per frame for the robot steering logic.

Parameters:
- IMG_W, 320, pixels per line (column counter wrap).
- IMG_H, 240, lines per frame (row counter saturates at IMG_H-1).
- MIN_PIXELS, 16, minimum red count for target_found.
- SUM_W, 25, accumulator/dividend width (must hold (IMG_W-1)*IMG_W*IMG_H).
- CNT_W, 17, count/divisor width.

Ports:
- clk  in  1  pixel clock (same domain as colour detection)
- reset_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel beat qualifier; no backpressure
- pix_red  in  1  current beat classified red
- pix_sop  in  1  first beat of frame, qualified by pix_valid
- pix_eop  in  1  last beat of frame, qualified by pix_valid
- centroid_x  out  9  floor(sum_x/count)
- centroid_y  out  8  floor(sum_y/count)
- red_count  out  CNT_W  red pixels in last published frame
- target_found  out  1  red_count >= MIN_PIXELS
- centroid_valid  out  1  one-cycle strobe, new results
- busy  out  1  divider FSM not IDLE
- overrun  out  1  sticky; frame dropped because divider busy; cleared only by reset

Behaviour:
- Reset (async assert, sync release): all outputs 0; counters, accumulators, FSM cleared; FSM = IDLE.
- Coordinates:
  - col/row counters advance on pix_valid only.
  - On a beat with pix_sop, the beat is (0,0).
  - Otherwise col increments; at IMG_W-1 col wraps to 0 and row increments; row saturates at IMG_H-1.
- Accumulation, on each pix_valid && pix_red beat: sum_x += col, sum_y += row, count += 1.
- pix_sop clears sum_x, sum_y and count before the current beat is accumulated. A mid-frame sop therefore discards the partial frame silently.
- On a pix_eop beat, the snapshot registers capture sum + current beat contribution; accumulators clear the same cycle.
  - If FSM is IDLE, it starts the divide.
  - If FSM is not IDLE, the snapshot is not taken, overrun is set, and the in-flight division completes unaffected.
- Simultaneous pix_sop and pix_eop on the same beat: a one-pixel frame. Clear, accumulate and snapshot all happen, in that order.
- FSM:
  - IDLE -> DIV_X on accepted eop.
  - DIV_X: SUM_W cycles, restoring divide snap_x / snap_cnt.
  - -> DIV_Y: SUM_W cycles, snap_y / snap_cnt.
  - -> PUBLISH: 1 cycle; update outputs, pulse centroid_valid.
  - -> IDLE.
- Latency: centroid_valid is high exactly 2*SUM_W+1 cycles after the eop beat (51 at defaults).
- Zero count: the divider is still run for fixed latency; centroid_x/y are forced to 0; target_found = 0.
- Quotient truncated to 9/8 bits; never exceeds IMG_W-1/IMG_H-1 by construction.
- Outputs hold their values between publishes.
- busy = (FSM != IDLE).
- Reset mid-division: the division is abandoned; outputs return to 0; no centroid_valid is issued.

Optional Feature:
- Macro: RED_CENTROID_BBOX_EN.
- When defined:
  - Adds outputs bbox_xmin/bbox_xmax (9 bits) and bbox_ymin/bbox_ymax (8 bits).
  - These are tracked per frame via min/max compare on red beats.
  - They are snapshotted with the sums and published in the PUBLISH cycle.
  - With zero count they publish as all zeros.
- When undefined: the ports and compare logic are absent; all other behaviour is identical.

Decomposition:
- Package red_centroid_pkg holds:
  - IMG_W/IMG_H defaults
  - coordinate widths (X_W=9, Y_W=8)
  - SUM_W/CNT_W
  - FSM state enum: IDLE, DIV_X, DIV_Y, PUBLISH
- Sub-module serial_divider (parameterised dividend/divisor widths):
  - start, busy, done, quotient
  - one quotient bit per cycle
  - instantiated once and reused for X then Y

Test Plan:
- Single red pixel at (10,5) in an otherwise black frame -> after 51 cycles: centroid_valid=1, centroid=(10,5), red_count=1, target_found=0.
- Red block x 100..109, y 50..59 -> red_count=100, centroid=(104,54) (floor of 104.5/54.5), target_found=1; with BBOX_EN: bbox=(100,109,50,59).
- All-black frame -> red_count=0, centroid=(0,0), target_found=0, centroid_valid still at 51 cycles.
- Second eop injected 20 cycles after the first -> overrun=1, first frame's results published correctly, no second centroid_valid.
- Sop asserted mid-frame after 500 red beats, then 16 red pixels at column 200 of row 3 -> red_count=16, centroid=(207,3) per the col/row reset at sop.
- reset_n pulsed low during DIV_Y -> all outputs 0 immediately, busy=0, no centroid_valid; next full frame publishes normally.
